morph_bin_filter: RTL and testbench
===================================

# morph_bin_filter

Parametrised binary morphology filter for the 1-bit video path between binarisation and target extraction. It generalises the fixed 3x3 dilation stage to a KSIZE x KSIZE window with run-time selectable dilation, erosion or bypass, and embeds its own line buffering. Pixels outside the frame are replaced by the neutral element of the active operation, so frame edges produce no artefacts.

## Interface
- IMG_HDISP, 10'd320, active pixels per line; line-buffer depth
- IMG_VDISP, 10'd240, active lines per frame; row-counter saturation value
- KSIZE, 3, kernel edge; legal values 3 or 5, any other value is an elaboration error; R = (KSIZE-1)/2
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- per_frame_vsync  in  1  input frame sync
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel strobe
- per_img_bit  in  1  input pixel, 1 = white
- cfg_mode  in  2  00 bypass, 01 dilate, 10 erode, 11 treated as bypass
- post_frame_vsync  out  1  per_frame_vsync delayed LAT clk
- post_frame_href  out  1  per_frame_href delayed LAT clk
- post_frame_clken  out  1  per_frame_clken delayed LAT clk
- post_img_bit  out  1  filtered pixel; forced 0 while post_frame_href = 0

## Operation
- Mode latch: cfg_mode sampled into mode_r on each rising edge of per_frame_vsync; constant for the whole frame. Reset value of mode_r is 01 (dilate).
- Counters: col_cnt increments per clken while href = 1, clears on href falling edge, saturates at IMG_HDISP-1. row_cnt increments on href falling edge, clears on vsync rising edge, saturates at IMG_VDISP-1.
- Line buffers: KSIZE-1 chained 1-bit buffers of depth IMG_HDISP, addressed by col_cnt, read-before-write on clken. Writes suppressed for pixels beyond IMG_HDISP in a line.
- Window: KSIZE x KSIZE shift register advances on clken only. Output at stream position (x,y) = op over input pixels (i,j) with x-2R <= i <= x, y-2R <= j <= y (window bottom-right aligned to current pixel; result is spatially shifted by (R,R), downstream compensates).
- Border masking: window row k above current (k = 1..KSIZE-1) is neutral if row_cnt < k; window column c back is neutral if col_cnt < c. Neutral = 0 for dilate, 1 for erode.
- Dilate = OR of all KSIZE² taps; erode = AND; bypass = current pixel (delayed).
- Line buffer contents are not reset; masking makes stale data invisible.

## Timing
- LAT = 3 clk, fixed, independent of KSIZE: stage 1 masked window register, stage 2 per-row reduction, stage 3 final reduction + mode mux.
- Stages 2-3 register every clk; data is valid when post_frame_clken = 1.
- Reset: all outputs 0, counters 0, sync delay lines 0, mode_r = 01. Asserting rst mid-frame: outputs 0 within the same cycle; after release the remainder of that frame is processed with row_cnt = 0 (top-border masking) until the next vsync rising edge.
- mode change on cfg_mode mid-frame has no effect until next vsync rising edge.
- vsync rising edge coincident with href: counter clear takes priority over increment.

## Structure
- Package morph_pkg: mode encodings (MODE_BYPASS, MODE_DILATE, MODE_ERODE), LAT constant, KSIZE legality check function.
- Sub-module morph_line_buffer (1-bit, parameter DEPTH, read-before-write, enable = clken); instantiated KSIZE-1 times.

## Test plan
- KSIZE=3, dilate, 8x6 frame all 0 with single 1 at (3,2) -> 3x3 block of 1s covering x 3..5, y 2..4 in output stream, all else 0, output delayed 3 clk.
- KSIZE=3, erode, all-1 frame -> all-1 output including first two rows/columns (neutral border).
- KSIZE=5, erode, all-1 frame with single 0 at (4,4) -> 5x5 block of 0s at x 4..8, y 4..8.
- cfg_mode switched 01->10 mid-frame -> current frame stays dilated; next frame eroded. cfg_mode 11 -> output equals input delayed 3 clk.
- href high with clken gaps (1 pixel every 2 clk) -> identical pixel results to gapless run; post_img_bit 0 whenever post_frame_href 0.
- rst pulsed mid-line -> all outputs 0 immediately; subsequent frame after next vsync matches golden model bit-exactly.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared mode encodings, sync bundle and constants for the binary morphology filter.
// Declarations only: no latency, no flow control.
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DILATE = 2'b01,
        MODE_ERODE  = 2'b10,
        MODE_RSVD   = 2'b11
    } morph_mode_e;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    localparam int LAT = 3;

    function automatic bit ksize_legal(input int ksize);
        return (ksize == 3) || (ksize == 5);
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// One-line 1-bit delay memory; asynchronous read returns the old word while the write lands on the edge.
// Read is combinational; writes happen only when en is high, with no backpressure.
module morph_line_buffer #(
    parameter int DEPTH = 320,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic          wr_dat,
    output logic          rd_dat
);

    logic mem [DEPTH];

    assign rd_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/morph_bin_filter.sv
// KSIZE x KSIZE binary dilate/erode/bypass filter with its own line buffers and out-of-frame masking.
// Latency is a fixed 3 clk for data and syncs; it has no backpressure and follows per_frame_clken.
module morph_bin_filter
    import morph_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP = 10'd320,
    parameter logic [9:0] IMG_VDISP = 10'd240,
    parameter int         KSIZE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_bit,
    input  logic [1:0] cfg_mode,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_bit
);

    localparam int         AW      = $clog2(IMG_HDISP);
    localparam logic [9:0] COL_MAX = IMG_HDISP - 10'd1;
    localparam logic [9:0] ROW_MAX = IMG_VDISP - 10'd1;

    if (!ksize_legal(KSIZE)) begin : g_bad_ksize
        $error("morph_bin_filter: KSIZE must be 3 or 5");
    end

    sync_t                       sync_in;
    sync_t                       sync_pipe [LAT];
    morph_mode_e                 mode_r;
    morph_mode_e                 mode_s1;
    morph_mode_e                 mode_s2;
    logic                        vsync_d;
    logic                        href_d;
    logic                        vs_rise;
    logic                        hs_fall;
    logic                        pix_en;
    logic                        lb_wr;
    logic [9:0]                  col_cnt;
    logic [9:0]                  row_cnt;
    logic                        col_full;
    logic                        col_in [KSIZE];
    logic [KSIZE-1:0]            col_now;
    logic [KSIZE-1:0]            hist [KSIZE-1];
    logic [KSIZE-1:0][KSIZE-1:0] win_mask;
    logic [KSIZE-1:0][KSIZE-1:0] win_s1;
    logic [KSIZE-1:0]            row_or_s2;
    logic [KSIZE-1:0]            row_and_s2;
    logic                        cur_s2;
    logic                        neutral;
    logic                        result;

    assign pix_en  = per_frame_clken & per_frame_href;
    assign vs_rise = per_frame_vsync & ~vsync_d;
    assign hs_fall = href_d & ~per_frame_href;
    assign lb_wr   = pix_en & ~col_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            mode_r   <= MODE_DILATE;
            col_cnt  <= '0;
            row_cnt  <= '0;
            col_full <= 1'b0;
        end else begin
            vsync_d <= per_frame_vsync;
            href_d  <= per_frame_href;
            if (vs_rise) begin
                mode_r <= morph_mode_e'(cfg_mode);
            end
            // Frame start wins over any line-level update in the same cycle.
            if (vs_rise || hs_fall) begin
                col_cnt  <= '0;
                col_full <= 1'b0;
            end else if (pix_en) begin
                if (col_cnt == COL_MAX) begin
                    col_full <= 1'b1;
                end else begin
                    col_cnt <= col_cnt + 10'd1;
                end
            end
            if (vs_rise) begin
                row_cnt <= '0;
            end else if (hs_fall && (row_cnt != ROW_MAX)) begin
                row_cnt <= row_cnt + 10'd1;
            end
        end
    end

    // col_in[k] is the pixel k lines above the current one at the same column.
    assign col_in[0] = per_img_bit;

    for (genvar k = 1; k < KSIZE; k++) begin : g_lb
        morph_line_buffer #(
            .DEPTH (int'(IMG_HDISP)),
            .AW    (AW)
        ) u_lb (
            .clk    (clk),
            .en     (lb_wr),
            .addr   (col_cnt[AW-1:0]),
            .wr_dat (col_in[k-1]),
            .rd_dat (col_in[k])
        );
    end

    always_comb begin
        col_now = '0;
        for (int k = 0; k < KSIZE; k++) begin
            col_now[k] = col_in[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
                hist[c] <= '0;
            end
        end else if (pix_en) begin
            hist[0] <= col_now;
            for (int c = 1; c < KSIZE - 1; c++) begin
                hist[c] <= hist[c-1];
            end
        end
    end

    // Taps that fall above the frame or left of the line take the operation's neutral value.
    always_comb begin
        win_mask = '0;
        neutral  = (mode_r == MODE_ERODE);
        for (int k = 0; k < KSIZE; k++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if ((int'(row_cnt) < k) || (int'(col_cnt) < c)) begin
                    win_mask[k][c] = neutral;
                end else if (c == 0) begin
                    win_mask[k][c] = col_now[k];
                end else begin
                    win_mask[k][c] = hist[c-1][k];
                end
            end
        end
    end

    assign sync_in = {per_frame_vsync, per_frame_href, per_frame_clken};

    always_comb begin
        result = cur_s2;
        case (mode_s2)
            MODE_DILATE: result = |row_or_s2;
            MODE_ERODE:  result = &row_and_s2;
            default:     result = cur_s2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                sync_pipe[i] <= '0;
            end
            win_s1       <= '0;
            mode_s1      <= MODE_DILATE;
            row_or_s2    <= '0;
            row_and_s2   <= '0;
            cur_s2       <= 1'b0;
            mode_s2      <= MODE_DILATE;
            post_img_bit <= 1'b0;
        end else begin
            sync_pipe[0] <= sync_in;
            for (int i = 1; i < LAT; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
            win_s1  <= win_mask;
            mode_s1 <= mode_r;
            for (int k = 0; k < KSIZE; k++) begin
                row_or_s2[k]  <= |win_s1[k];
                row_and_s2[k] <= &win_s1[k];
            end
            cur_s2       <= win_s1[0][0];
            mode_s2      <= mode_s1;
            post_img_bit <= sync_pipe[LAT-2].href & result;
        end
    end

    assign post_frame_vsync = sync_pipe[LAT-1].vsync;
    assign post_frame_href  = sync_pipe[LAT-1].href;
    assign post_frame_clken = sync_pipe[LAT-1].clken;

endmodule

// File: tb/tb_morph_bin_filter.sv
// Drives KSIZE=3 and KSIZE=5 filters with the same frames and checks them against a window-level reference.
module tb_morph_bin_filter;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       href;
    logic       clken;
    logic       pix;
    logic [1:0] cfg_mode;
    logic       o3_vs, o3_hs, o3_ck, o3_px;
    logic       o5_vs, o5_hs, o5_ck, o5_px;

    int         n_tests;
    int         n_fail;
    int         lat_err;
    int         href0_err;
    logic [7:0] rst_out;
    logic [2:0] ep0, ep1, ep2;
    bit         img [16][16];
    bit         q3 [$];
    bit         q5 [$];

    morph_bin_filter #(.KSIZE(3)) dut3 (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_bit(pix), .cfg_mode(cfg_mode),
        .post_frame_vsync(o3_vs), .post_frame_href(o3_hs),
        .post_frame_clken(o3_ck), .post_img_bit(o3_px)
    );

    morph_bin_filter #(.KSIZE(5)) dut5 (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_img_bit(pix), .cfg_mode(cfg_mode),
        .post_frame_vsync(o5_vs), .post_frame_href(o5_hs),
        .post_frame_clken(o5_ck), .post_img_bit(o5_px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: op over the (k x k) input block ending at (x,y); out-of-frame taps are skipped.
    function automatic bit model_px(input int k, input logic [1:0] mode, input int x, input int y);
        bit acc;
        if (mode == 2'b01 || mode == 2'b10) begin
            acc = (mode == 2'b10);
            for (int j = y - k + 1; j <= y; j++) begin
                for (int i = x - k + 1; i <= x; i++) begin
                    if (i >= 0 && j >= 0) begin
                        if (mode == 2'b01) acc = acc | img[j][i];
                        else               acc = acc & img[j][i];
                    end
                end
            end
        end else begin
            acc = img[y][x];
        end
        return acc;
    endfunction

    function automatic int px_errs(input int k, input logic [1:0] mode, input int w, input int h);
        int e;
        bit got;
        e = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                got = (k == 3) ? q3[y*w+x] : q5[y*w+x];
                if (got != model_px(k, mode, x, y)) e++;
            end
        end
        return e;
    endfunction

    task automatic fill(input int w, input int h, input int kind);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                if (y >= h || x >= w) img[y][x] = 1'b0;
                else if (kind == 2)   img[y][x] = (($urandom % 3) == 0);
                else                  img[y][x] = (kind == 1);
            end
        end
    endtask

    // One clock: drive inputs after the edge, sample outputs on the falling edge.
    task automatic tick(input logic v, input logic h, input logic c, input logic p, input logic r);
        @(posedge clk);
        if (rst) begin
            ep0 = '0; ep1 = '0; ep2 = '0;
        end else begin
            ep2 = ep1; ep1 = ep0; ep0 = {vsync, href, clken};
        end
        #1;
        vsync = v; href = h; clken = c; pix = p; rst = r;
        if (r) begin
            ep0 = '0; ep1 = '0; ep2 = '0;
        end
        @(negedge clk);
        if ({o3_vs, o3_hs, o3_ck} !== ep2 || {o5_vs, o5_hs, o5_ck} !== ep2) lat_err++;
        if ((!o3_hs && o3_px) || (!o5_hs && o5_px)) href0_err++;
        if (o3_ck) q3.push_back(o3_px);
        if (o5_ck) q5.push_back(o5_px);
        if (r) rst_out = rst_out | {o3_vs, o3_hs, o3_ck, o3_px, o5_vs, o5_hs, o5_ck, o5_px};
    endtask

    task automatic run_frame(input int w, input int h, input int gap, input logic [1:0] m0,
                             input logic [1:0] m1, input int rst_y, input int rst_x);
        logic c;
        logic r;
        q3.delete(); q5.delete();
        lat_err = 0; href0_err = 0; rst_out = '0;
        cfg_mode = m0;
        repeat (2) tick(0, 0, 0, 0, 0);
        repeat (2) tick(1, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        for (int y = 0; y < h; y++) begin
            if (y == 1) cfg_mode = m1;
            for (int x = 0; x < w; x++) begin
                for (int g = 0; g < gap; g++) begin
                    c = (g == gap - 1);
                    r = (y == rst_y) && (x >= rst_x) && (x < rst_x + 2);
                    tick(0, 1, c, c ? img[y][x] : (($urandom & 1) != 0), r);
                end
            end
            repeat (3) tick(0, 0, 0, 0, 0);
        end
        repeat (6) tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        repeat (3) tick(0, 0, 0, 0, 1);
        n_tests++;
        if ({o3_vs, o3_hs, o3_ck, o3_px} !== 4'b0) begin
            n_fail++; $display("FAIL reset_out_k3: got %b, expected 0000", {o3_vs, o3_hs, o3_ck, o3_px});
        end
        n_tests++;
        if ({o5_vs, o5_hs, o5_ck, o5_px} !== 4'b0) begin
            n_fail++; $display("FAIL reset_out_k5: got %b, expected 0000", {o5_vs, o5_hs, o5_ck, o5_px});
        end
        lat_err = 0;
        repeat (4) tick(0, 0, 0, 0, 0);
        n_tests++;
        if (lat_err !== 0) begin
            n_fail++; $display("FAIL reset_release_syncs: got %0d bad cycles, expected 0", lat_err);
        end
    endtask

    task automatic test_dilate_point();
        int ones;
        fill(8, 6, 0);
        img[2][3] = 1'b1;
        run_frame(8, 6, 1, 2'b01, 2'b01, -1, 0);
        n_tests++;
        if (q3.size() !== 48) begin
            n_fail++; $display("FAIL dil_pt_count: got %0d pixels, expected 48", q3.size());
        end
        ones = 0;
        foreach (q3[i]) ones += int'(q3[i]);
        n_tests++;
        if (ones !== 9) begin
            n_fail++; $display("FAIL dil_pt_ones: got %0d, expected 9", ones);
        end
        n_tests++;
        if (q3[4*8+5] !== 1'b1 || q3[2*8+3] !== 1'b1 || q3[4*8+6] !== 1'b0 || q3[1*8+3] !== 1'b0) begin
            n_fail++; $display("FAIL dil_pt_corners: got %b%b%b%b, expected 1100",
                               q3[4*8+5], q3[2*8+3], q3[4*8+6], q3[1*8+3]);
        end
        n_tests++;
        if (px_errs(3, 2'b01, 8, 6) !== 0 || px_errs(5, 2'b01, 8, 6) !== 0) begin
            n_fail++; $display("FAIL dil_pt_model: got %0d/%0d bad pixels, expected 0/0",
                               px_errs(3, 2'b01, 8, 6), px_errs(5, 2'b01, 8, 6));
        end
        n_tests++;
        if (lat_err !== 0) begin
            n_fail++; $display("FAIL dil_pt_latency: got %0d bad cycles, expected 0", lat_err);
        end
    endtask

    task automatic test_erode_full();
        int ones;
        fill(10, 10, 1);
        run_frame(10, 10, 1, 2'b10, 2'b10, -1, 0);
        ones = 0;
        foreach (q3[i]) ones += int'(q3[i]);
        n_tests++;
        if (ones !== 100 || q3.size() !== 100) begin
            n_fail++; $display("FAIL ero_full_k3: got %0d ones of %0d, expected 100 of 100", ones, q3.size());
        end
        ones = 0;
        foreach (q5[i]) ones += int'(q5[i]);
        n_tests++;
        if (ones !== 100 || q5.size() !== 100) begin
            n_fail++; $display("FAIL ero_full_k5: got %0d ones of %0d, expected 100 of 100", ones, q5.size());
        end
    endtask

    task automatic test_erode_k5_hole();
        int zeros;
        fill(12, 10, 1);
        img[4][4] = 1'b0;
        run_frame(12, 10, 1, 2'b10, 2'b10, -1, 0);
        zeros = 0;
        foreach (q5[i]) zeros += int'(!q5[i]);
        n_tests++;
        if (zeros !== 25 || q5.size() !== 120) begin
            n_fail++; $display("FAIL ero_hole_zeros: got %0d zeros of %0d, expected 25 of 120", zeros, q5.size());
        end
        n_tests++;
        if (q5[8*12+8] !== 1'b0 || q5[4*12+4] !== 1'b0 || q5[9*12+9] !== 1'b1 || q5[4*12+3] !== 1'b1) begin
            n_fail++; $display("FAIL ero_hole_corners: got %b%b%b%b, expected 0011",
                               q5[8*12+8], q5[4*12+4], q5[9*12+9], q5[4*12+3]);
        end
        n_tests++;
        if (px_errs(3, 2'b10, 12, 10) !== 0) begin
            n_fail++; $display("FAIL ero_hole_k3: got %0d bad pixels, expected 0", px_errs(3, 2'b10, 12, 10));
        end
    endtask

    task automatic test_mode_switch();
        int e;
        fill(10, 7, 2);
        run_frame(10, 7, 1, 2'b01, 2'b10, -1, 0);
        n_tests++;
        if (px_errs(3, 2'b01, 10, 7) !== 0 || px_errs(5, 2'b01, 10, 7) !== 0) begin
            n_fail++; $display("FAIL mode_hold_dilate: got %0d/%0d bad pixels, expected 0/0",
                               px_errs(3, 2'b01, 10, 7), px_errs(5, 2'b01, 10, 7));
        end
        run_frame(10, 7, 1, 2'b10, 2'b10, -1, 0);
        n_tests++;
        if (px_errs(3, 2'b10, 10, 7) !== 0 || px_errs(5, 2'b10, 10, 7) !== 0) begin
            n_fail++; $display("FAIL mode_next_erode: got %0d/%0d bad pixels, expected 0/0",
                               px_errs(3, 2'b10, 10, 7), px_errs(5, 2'b10, 10, 7));
        end
        run_frame(10, 7, 1, 2'b11, 2'b01, -1, 0);
        e = 0;
        for (int y = 0; y < 7; y++) begin
            for (int x = 0; x < 10; x++) begin
                if (q3[y*10+x] != img[y][x] || q5[y*10+x] != img[y][x]) e++;
            end
        end
        n_tests++;
        if (e !== 0 || q3.size() !== 70) begin
            n_fail++; $display("FAIL mode_bypass: got %0d bad of %0d, expected 0 of 70", e, q3.size());
        end
        n_tests++;
        if (lat_err !== 0) begin
            n_fail++; $display("FAIL mode_bypass_latency: got %0d bad cycles, expected 0", lat_err);
        end
    endtask

    task automatic test_clken_gaps();
        logic [1:0] m;
        fill(9, 8, 2);
        m = (($urandom & 1) != 0) ? 2'b01 : 2'b10;
        run_frame(9, 8, 2, m, m, -1, 0);
        n_tests++;
        if (q3.size() !== 72 || px_errs(3, m, 9, 8) !== 0 || px_errs(5, m, 9, 8) !== 0) begin
            n_fail++; $display("FAIL gaps_pixels: got %0d pixels, %0d/%0d bad, expected 72, 0/0",
                               q3.size(), px_errs(3, m, 9, 8), px_errs(5, m, 9, 8));
        end
        n_tests++;
        if (href0_err !== 0) begin
            n_fail++; $display("FAIL gaps_href_low_bit: got %0d cycles with bit set, expected 0", href0_err);
        end
        n_tests++;
        if (lat_err !== 0) begin
            n_fail++; $display("FAIL gaps_latency: got %0d bad cycles, expected 0", lat_err);
        end
    endtask

    task automatic test_random_frames();
        int w, h, gap;
        logic [1:0] m;
        for (int f = 0; f < 5; f++) begin
            w   = $urandom_range(6, 16);
            h   = $urandom_range(6, 12);
            gap = $urandom_range(1, 2);
            m   = 2'($urandom_range(0, 3));
            fill(w, h, 2);
            run_frame(w, h, gap, m, m, -1, 0);
            n_tests++;
            if (q5.size() !== w*h || px_errs(3, m, w, h) !== 0 || px_errs(5, m, w, h) !== 0 || href0_err !== 0) begin
                n_fail++; $display("FAIL random_frame%0d (%0dx%0d mode %0d): got %0d px, %0d/%0d bad, %0d href0, expected %0d, 0/0, 0",
                                   f, w, h, m, q5.size(), px_errs(3, m, w, h), px_errs(5, m, w, h), href0_err, w*h);
            end
        end
    endtask

    task automatic test_rst_mid_line();
        fill(10, 8, 2);
        run_frame(10, 8, 1, 2'b10, 2'b10, 3, 4);
        n_tests++;
        if (rst_out !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b, expected 00000000", rst_out);
        end
        n_tests++;
        if (lat_err !== 0) begin
            n_fail++; $display("FAIL rst_mid_syncs: got %0d bad cycles, expected 0", lat_err);
        end
        fill(11, 9, 2);
        run_frame(11, 9, 1, 2'b10, 2'b10, -1, 0);
        n_tests++;
        if (q3.size() !== 99 || px_errs(3, 2'b10, 11, 9) !== 0 || px_errs(5, 2'b10, 11, 9) !== 0) begin
            n_fail++; $display("FAIL rst_next_frame: got %0d px, %0d/%0d bad, expected 99, 0/0",
                               q3.size(), px_errs(3, 2'b10, 11, 9), px_errs(5, 2'b10, 11, 9));
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; lat_err = 0; href0_err = 0; rst_out = '0;
        ep0 = '0; ep1 = '0; ep2 = '0;
        rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; pix = 1'b0; cfg_mode = 2'b01;
        test_reset();
        test_dilate_point();
        test_erode_full();
        test_erode_k5_hole();
        test_mode_switch();
        test_clken_gaps();
        test_random_frames();
        test_rst_mid_line();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
